// File: rtl/uart_rsp_pkg.sv
// Shared types and helpers for the UART response multiplexer.
//   state_e   : arbiter/FSM states
//   ch_idx_w  : bit width needed to hold a channel index
//   tag_mark  : channel-tag marker (MSB of a data word), 32-bit wide,
//               sliced by the user to the data width
package uart_rsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    DATA = 2'd2
  } state_e;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] tag_mark(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/uart_rsp_fifo.sv
// Single-clock FIFO for one response channel.
//   push_i/wdata_i : write side (ignored when full)
//   pop_i          : read side (ignored when empty)
//   rdata_o        : head word
//   rdata_nxt_o    : word that becomes head after a pop this cycle
//   full_o/empty_o : occupancy flags
//   last_o         : exactly one word stored
module uart_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [WIDTH-1:0] rdata_nxt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             last_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      occ;
  logic [AW-1:0]    rd_nxt_idx;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign occ        = wr_ptr_q - rd_ptr_q;
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign last_o     = (occ == (AW+1)'(1));
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign rd_nxt_idx = rd_ptr_q[AW-1:0] + AW'(1);

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  // With a single word stored, the successor is the word being written now.
  assign rdata_nxt_o = last_o ? wdata_i : mem_q[rd_nxt_idx];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rsp_mux.sv
// Merges NUM_CH buffered response streams into one UART response stream,
// round-robin, up to BURST_MAX words per grant, optional channel tag word.
//   ch_val_i/ch_data_i/ch_rdy_o             : per-channel input handshakes
//   uart_rsp_data_o/uart_rsp_val_o/uart_rsp_rdy_i : merged output
//   busy_o                                  : any FIFO non-empty or FSM active
//
// state | meaning
// IDLE  | no grant; arbitrate among requesting channels
// TAG   | presenting tag word (TAG_MARK | grant)
// DATA  | presenting head word of granted FIFO
module uart_rsp_mux
  import uart_rsp_pkg::*;
#(
  parameter int UART_DATA_WIDTH = 8,
  parameter int NUM_CH          = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int BURST_MAX       = 4,
  parameter int TAG_EN          = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_CH-1:0]                 ch_val_i,
  input  logic [NUM_CH*UART_DATA_WIDTH-1:0] ch_data_i,
  output logic [NUM_CH-1:0]                 ch_rdy_o,
  input  logic                              uart_rsp_rdy_i,
  output logic [UART_DATA_WIDTH-1:0]        uart_rsp_data_o,
  output logic                              uart_rsp_val_o,
  output logic                              busy_o
);

  localparam int W     = UART_DATA_WIDTH;
  localparam int CH_W  = ch_idx_w(NUM_CH);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [31:0]      TAG_MARK32 = tag_mark(UART_DATA_WIDTH);
  localparam logic [W-1:0]     TAG_MARK   = TAG_MARK32[W-1:0];
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] push, pop, full, empty, last;
  logic [W-1:0]      head     [NUM_CH];
  logic [W-1:0]      head_nxt [NUM_CH];

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              val_q, val_d;
  logic [W-1:0]      data_q, data_d;
  logic [NUM_CH-1:0] req_q, req_d;

  logic              hs;
  logic              arb_found;
  logic [CH_W-1:0]   arb_idx;

  assign push     = ch_val_i & ~full;
  assign ch_rdy_o = ~full;
  assign hs       = val_q & uart_rsp_rdy_i;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_fifo
    uart_rsp_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (push[gi]),
      .wdata_i     (ch_data_i[gi*W +: W]),
      .pop_i       (pop[gi]),
      .rdata_o     (head[gi]),
      .rdata_nxt_o (head_nxt[gi]),
      .full_o      (full[gi]),
      .empty_o     (empty[gi]),
      .last_o      (last[gi])
    );
  end

  // Arbitration request: a word landing in an empty FIFO becomes eligible one
  // cycle later, while a pop that drains a FIFO withdraws it immediately so a
  // drained channel can never be granted.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      req_d[i] = ~empty[i] & ~(pop[i] & last[i] & ~push[i]);
    end
  end

  // Round-robin: first requester searching from ptr+1 with wrap-around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!arb_found && req_q[(int'(ptr_q) + k) % NUM_CH]) begin
        arb_found = 1'b1;
        arb_idx   = CH_W'((int'(ptr_q) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    data_d  = data_q;
    pop     = '0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          ptr_d   = arb_idx;
          cnt_d   = '0;
          val_d   = 1'b1;
          if (TAG_EN != 0) begin
            state_d = TAG;
            data_d  = TAG_MARK | W'(arb_idx);
          end else begin
            state_d = DATA;
            data_d  = head[arb_idx];
          end
        end
      end
      TAG: begin
        if (hs) begin
          state_d = DATA;
          data_d  = head[grant_q];
        end
      end
      DATA: begin
        if (hs) begin
          pop[grant_q] = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == BURST_LAST || (last[grant_q] && !push[grant_q])) begin
            state_d = IDLE;
            val_d   = 1'b0;
            data_d  = '0;
          end else begin
            data_d = head_nxt[grant_q];
          end
        end
      end
      default: begin
        state_d = IDLE;
        val_d   = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= CH_LAST;
      cnt_q   <= '0;
      val_q   <= 1'b0;
      data_q  <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      data_q  <= data_d;
      req_q   <= req_d;
    end
  end

  assign uart_rsp_val_o  = val_q;
  assign uart_rsp_data_o = data_q;
  assign busy_o          = (state_q != IDLE) | ~(&empty);

endmodule
